// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispenser: change codes, FSM states,
// and the change-code to coin-count mapping.
package vend_pkg;

    // Change codes, shared with the acceptor FSM
    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_FAULT
    } state_t;

    // Number of 5-rs coins owed for a change code; the illegal code owes nothing
    function automatic logic [1:0] coins_for(input logic [1:0] code);
        case (code)
            CHG_5:   return 2'd1;
            CHG_10:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// Acceptor/actuator-side signal bundle of the dispenser.
// master: the acceptor FSM and sensors; slave: the dispenser itself.
interface vend_dispenser_if #(
    parameter int unsigned COIN_W = 8
);
    logic              item_req;
    logic [1:0]        change_req;
    logic              coin_sense;
    logic              refill;
    logic              motor_en;
    logic              coin_pulse;
    logic              busy;
    logic              done;
    logic              short_pay;
    logic              req_err;
    logic              fault;
    logic              coin_empty;
    logic [COIN_W-1:0] coin_count;

    modport master (
        output item_req, change_req, coin_sense, refill,
        input  motor_en, coin_pulse, busy, done, short_pay, req_err,
               fault, coin_empty, coin_count
    );

    modport slave (
        input  item_req, change_req, coin_sense, refill,
        output motor_en, coin_pulse, busy, done, short_pay, req_err,
               fault, coin_empty, coin_count
    );
endinterface

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter; zero flags the last cycle of a timed state.
// Loading L-1 on state entry makes the state last L cycles.
module vend_cycle_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // Count down to zero and hold there until reloaded
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Vend dispenser: runs the item motor and the 5-rs coin hopper from the
// acceptor's vend decision, tracks hopper inventory and latches faults.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned COIN_W       = 8,
    parameter int unsigned COIN_INIT    = 20
) (
    input logic            clk,
    input logic            rst,
    vend_dispenser_if.slave bus
);
    localparam int unsigned TMR_W = 16;

    state_t            state_q, state_d;
    logic [1:0]        owed_q, owed_d;
    logic [COIN_W-1:0] count_q, count_d;
    logic              sensed_q, sensed_d;

    logic motor_en_q, coin_pulse_q, busy_q, fault_q;
    logic done_q, done_d;
    logic short_q, short_d;
    logic err_q, err_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    // Coin-service evaluation inputs
    logic              svc;
    logic [1:0]        svc_owed;
    logic [COIN_W-1:0] svc_count;

    vend_cycle_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state, inventory and pulse decisions.
    // Coin service is a zero-cycle decision taken when leaving IDLE, MOTOR
    // or GAP. Its "done" and "short_pay" outcomes park in a one-cycle GAP so
    // busy stays high for the done pulse and a short pay is re-evaluated on
    // the following cycle; done_q marks the final park before IDLE.
    always_comb begin
        state_d   = state_q;
        owed_d    = owed_q;
        count_d   = count_q;
        sensed_d  = sensed_q;
        done_d    = 1'b0;
        short_d   = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        svc       = 1'b0;
        svc_owed  = owed_q;
        svc_count = count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.refill) begin
                    count_d = COIN_W'(COIN_INIT);
                end
                if (bus.item_req || (bus.change_req != CHG_NONE)) begin
                    err_d  = (bus.change_req == CHG_ILL);
                    owed_d = coins_for(bus.change_req);
                    if (bus.item_req) begin
                        state_d  = ST_MOTOR;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(MOTOR_CYCLES - 1);
                    end else begin
                        svc       = 1'b1;
                        svc_owed  = owed_d;
                        svc_count = count_d;
                    end
                end
            end

            ST_MOTOR: begin
                if (tmr_zero) begin
                    svc = 1'b1;
                end
            end

            ST_PULSE: begin
                // An early sense counts once and makes WAIT_ACK unnecessary
                if (bus.coin_sense && !sensed_q) begin
                    sensed_d = 1'b1;
                    owed_d   = owed_q - 2'd1;
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end
                end
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (sensed_d) begin
                        state_d = ST_GAP;
                        tmr_val = TMR_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_WAIT_ACK;
                        tmr_val = TMR_W'(ACK_TIMEOUT - 1);
                    end
                end
            end

            ST_WAIT_ACK: begin
                if (bus.coin_sense) begin
                    owed_d   = owed_q - 2'd1;
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYCLES - 1);
                end else if (tmr_zero) begin
                    state_d = ST_FAULT;
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        svc = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase

        if (svc) begin
            tmr_load = 1'b1;
            if (svc_owed == 2'd0) begin
                done_d  = 1'b1;
                state_d = ST_GAP;
                tmr_val = '0;
            end else if (svc_count == '0) begin
                short_d = 1'b1;
                owed_d  = svc_owed - 2'd1;
                state_d = ST_GAP;
                tmr_val = '0;
            end else begin
                sensed_d = 1'b0;
                state_d  = ST_PULSE;
                tmr_val  = TMR_W'(PULSE_CYCLES - 1);
            end
        end
    end

    // State, inventory and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owed_q       <= '0;
            count_q      <= COIN_W'(COIN_INIT);
            sensed_q     <= 1'b0;
            motor_en_q   <= 1'b0;
            coin_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owed_q       <= owed_d;
            count_q      <= count_d;
            sensed_q     <= sensed_d;
            motor_en_q   <= (state_d == ST_MOTOR);
            coin_pulse_q <= (state_d == ST_PULSE);
            busy_q       <= (state_d != ST_IDLE);
            fault_q      <= (state_d == ST_FAULT);
            done_q       <= done_d;
            short_q      <= short_d;
            err_q        <= err_d;
        end
    end

    assign bus.motor_en   = motor_en_q;
    assign bus.coin_pulse = coin_pulse_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.short_pay  = short_q;
    assign bus.req_err    = err_q;
    assign bus.fault      = fault_q;
    assign bus.coin_count = count_q;
    assign bus.coin_empty = (count_q == '0);

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser with hand-computed cycle positions.
// Cycle 1 of a capture is the cycle right after the request edge.
module tb_vend_dispenser;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int n_motor, first_motor, last_motor, n_pulse, n_groups;
    int n_done, done_at, n_short, short_at, n_err, err_at, busy_end, fault_at;

    vend_dispenser_if #(.COIN_W(8)) bus ();

    vend_dispenser #(
        .MOTOR_CYCLES (8),
        .PULSE_CYCLES (4),
        .GAP_CYCLES   (4),
        .ACK_TIMEOUT  (16),
        .COIN_W       (8),
        .COIN_INIT    (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic item, input logic [1:0] chg, input logic rf);
        bus.item_req   = item;
        bus.change_req = chg;
        bus.refill     = rf;
    endtask

    task automatic request(input logic item, input logic [1:0] chg, input logic rf);
        drive(item, chg, rf);
        cyc();
        drive(1'b0, CHG_NONE, 1'b0);
    endtask

    // Observe n cycles; optionally ack each coin in its first WAIT_ACK cycle,
    // pulse coin_sense in cycle sense_c, and inject a request+refill in inj_c.
    task automatic capture(input int n, input bit auto_ack, input int sense_c, input int inj_c);
        logic prev_pulse;
        prev_pulse = 1'b0;
        n_motor = 0; first_motor = 0; last_motor = 0; n_pulse = 0; n_groups = 0;
        n_done = 0; done_at = 0; n_short = 0; short_at = 0; n_err = 0; err_at = 0;
        busy_end = 0; fault_at = 0;
        for (int c = 1; c <= n; c++) begin
            if (bus.motor_en) begin
                n_motor++;
                if (first_motor == 0) first_motor = c;
                last_motor = c;
            end
            if (bus.coin_pulse) begin
                n_pulse++;
                if (!prev_pulse) n_groups++;
            end
            if (bus.done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            if (bus.short_pay) begin
                n_short++;
                if (short_at == 0) short_at = c;
            end
            if (bus.req_err) begin
                n_err++;
                if (err_at == 0) err_at = c;
            end
            if (bus.busy) busy_end = c;
            if (bus.fault && fault_at == 0) fault_at = c;
            bus.coin_sense = (auto_ack && prev_pulse && !bus.coin_pulse) || (c == sense_c);
            if (c == inj_c) drive(1'b1, CHG_5, 1'b1);
            else            drive(1'b0, CHG_NONE, 1'b0);
            prev_pulse = bus.coin_pulse;
            cyc();
        end
        bus.coin_sense = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.coin_sense = 1'b0;
        drive(1'b0, CHG_NONE, 1'b0);
        repeat (3) cyc();
        check("rst_motor", bus.motor_en, 0);
        check("rst_pulse", bus.coin_pulse, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_count", bus.coin_count, 20);
        check("rst_empty", bus.coin_empty, 0);
        rst = 1'b0;
        cyc();

        // Item only
        request(1'b1, CHG_NONE, 1'b0);
        capture(14, 1'b0, 0, 0);
        check("item_motor_n", n_motor, 8);
        check("item_motor_first", first_motor, 1);
        check("item_motor_last", last_motor, 8);
        check("item_done_at", done_at, 9);
        check("item_done_n", n_done, 1);
        check("item_busy_end", busy_end, 9);
        check("item_pulse_n", n_pulse, 0);
        check("item_count", bus.coin_count, 20);

        // Two coins, each acked in the first WAIT_ACK cycle
        request(1'b0, CHG_10, 1'b0);
        capture(25, 1'b1, 0, 0);
        check("c10_pulse_n", n_pulse, 8);
        check("c10_groups", n_groups, 2);
        check("c10_done_n", n_done, 1);
        check("c10_done_at", done_at, 19);
        check("c10_busy_end", busy_end, 19);
        check("c10_count", bus.coin_count, 18);

        // Sense during PULSE skips WAIT_ACK
        request(1'b0, CHG_5, 1'b0);
        capture(14, 1'b0, 2, 0);
        check("early_pulse_n", n_pulse, 4);
        check("early_done_at", done_at, 9);
        check("early_busy_end", busy_end, 9);
        check("early_fault", fault_at, 0);
        check("early_count", bus.coin_count, 17);

        // Drain the hopper down to one coin
        for (int k = 0; k < 16; k++) begin
            request(1'b0, CHG_5, 1'b0);
            capture(12, 1'b1, 0, 0);
        end
        check("drain_count", bus.coin_count, 1);

        // One coin left, item plus two owed
        request(1'b1, CHG_10, 1'b0);
        capture(24, 1'b1, 0, 0);
        check("short_motor_n", n_motor, 8);
        check("short_pulse_n", n_pulse, 4);
        check("short_n", n_short, 1);
        check("short_at", short_at, 18);
        check("short_done_at", done_at, 19);
        check("short_done_n", n_done, 1);
        check("short_count", bus.coin_count, 0);
        check("short_empty", bus.coin_empty, 1);

        // Empty hopper, one coin owed
        request(1'b0, CHG_5, 1'b0);
        capture(6, 1'b1, 0, 0);
        check("empty_short_n", n_short, 1);
        check("empty_short_at", short_at, 1);
        check("empty_done_at", done_at, 2);
        check("empty_busy_end", busy_end, 2);
        check("empty_pulse_n", n_pulse, 0);
        check("empty_count", bus.coin_count, 0);

        // Refill together with a request: request sees the refilled count
        request(1'b0, CHG_5, 1'b1);
        capture(14, 1'b1, 0, 0);
        check("refill_short_n", n_short, 0);
        check("refill_pulse_n", n_pulse, 4);
        check("refill_done_at", done_at, 10);
        check("refill_count", bus.coin_count, 19);
        check("refill_empty", bus.coin_empty, 0);

        // Illegal code with item; request+refill while busy ignored
        request(1'b1, CHG_ILL, 1'b0);
        capture(16, 1'b1, 0, 3);
        check("ill_err_n", n_err, 1);
        check("ill_err_at", err_at, 1);
        check("ill_motor_n", n_motor, 8);
        check("ill_pulse_n", n_pulse, 0);
        check("ill_done_n", n_done, 1);
        check("ill_done_at", done_at, 9);
        check("ill_busy_end", busy_end, 9);
        check("ill_count", bus.coin_count, 19);

        // Missing acknowledge ends in FAULT
        request(1'b0, CHG_5, 1'b0);
        capture(30, 1'b0, 0, 0);
        check("flt_at", fault_at, 21);
        check("flt_pulse_n", n_pulse, 4);
        check("flt_done_n", n_done, 0);
        check("flt_busy_end", busy_end, 30);
        request(1'b1, CHG_10, 1'b1);
        capture(4, 1'b0, 0, 0);
        check("flt_stuck_motor", n_motor, 0);
        check("flt_stuck_fault", bus.fault, 1);
        check("flt_stuck_busy", bus.busy, 1);
        check("flt_stuck_count", bus.coin_count, 19);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("flt_rst_fault", bus.fault, 0);
        check("flt_rst_busy", bus.busy, 0);
        check("flt_rst_count", bus.coin_count, 20);

        // Reset in the middle of PULSE
        request(1'b0, CHG_5, 1'b0);
        cyc();
        check("mid_pulse_on", bus.coin_pulse, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_pulse", bus.coin_pulse, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_motor", bus.motor_en, 0);
        check("mid_done", bus.done, 0);
        check("mid_fault", bus.fault, 0);
        check("mid_count", bus.coin_count, 20);
        capture(12, 1'b1, 0, 0);
        check("mid_after_done", n_done, 0);
        check("mid_after_pulse", n_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
